multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath.
- Decodes the instruction register fields op, funct3 and funct7[5], and sequences each instruction through a Moore FSM.
- Drives every datapath mux select and write enable.
- Drives ImmSrc, which selects the immediate format for the downstream immediate extender.

Parameters:
None. All encodings are fixed constants in the shared package.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-low reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
neg  in  1  ALU signed less-than flag (rs1 < rs2)
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register and OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A (rs1)
ALUSrcB  out  2  00 = B (rs2), 01 = ImmExt, 10 = constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal_op  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-ALU (addi, andi, ori, slti), jal, jalr, beq, bne, blt, bge, lui.
- ImmSrc is combinational from op in every state: lw/I-ALU/jalr 000, sw 001, branch 010, jal 011, lui 100, any other op 000.
- Unlisted outputs in a state are 0 (enables) or 00/000 (selects).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add, so ALUOut = OldPC+imm (branch/jal target). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - any other op: illegal_op=1 for this cycle only, next FETCH, no write enable asserted.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUControl from alu_decoder with funct7b5 honoured. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, alu_decoder with funct7b5 ignored (always add for funct3 000). Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, so PC = target and ALUOut = OldPC+4. Next ALUWB.
- JALR1: ALUSrcA=10, ALUSrcB=01, add, so ALUOut = rs1+imm. Next JALR2.
- JALR2: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add. Next ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - ALUControl = sub for beq/bne, slt for blt/bge.
  - taken: funct3 000 -> zero; 001 -> !zero; 100 -> neg; 101 -> !neg; others -> 0.
  - PCWrite = taken. Next FETCH.
- LUI: ResultSrc=11, RegWrite=1. Next FETCH.
- alu_decoder (funct3, funct7b5, rtype):
  - 000 -> sub if rtype & funct7b5, else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - others -> add
- Latency in cycles: lw 5, jalr 5, sw 4, R 4, I 4, jal 4, branch 3, lui 3, illegal 2.
- Reset:
  - While rst=0, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) and illegal_op are forced to 0; selects show FETCH values.
  - The first edge with rst=0 loads FETCH.
  - Reset asserted in any state (e.g. mid-MEMREAD) discards the instruction; no RegWrite or MemWrite is issued afterwards.
- Inputs zero and neg are sampled only in BRANCH; they are don't-care elsewhere.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - state enum
  - ImmSrc, ALUControl, ResultSrc, ALUSrcA and ALUSrcB encodings (shared with the extender and datapath)
- Sub-module alu_decoder, combinational: takes funct3, funct7b5 and rtype, returns ALUControl.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> PCWrite=IRWrite=RegWrite=MemWrite=0. Release -> first cycle shows IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcB=10.
- lw x5,8(x1) (0x0080A283) -> ImmSrc=000 in DECODE and MEMADR; AdrSrc=1 in cycle 4; RegWrite=1 with ResultSrc=01 only in cycle 5; then FETCH.
- sw x5,4(x1) (op 0100011) -> ImmSrc=001; MemWrite=1 with AdrSrc=1 only in cycle 4; RegWrite never 1.
- Branch, all with ImmSrc=010 and the decision in cycle 3:
  - beq with zero=1 -> PCWrite=1, ALUControl=001.
  - beq with zero=0 -> PCWrite=0.
  - blt with neg=1 -> taken, ALUControl=101.
  - bge with neg=1 -> not taken.
- jal (op 1101111):
  - ImmSrc=011; PCWrite=1 in cycle 3; RegWrite=1 with ResultSrc=00 in cycle 4.
  - jalr: PCWrite=1 in cycle 4, RegWrite=1 in cycle 5.
- lui (0x123452B7) -> ImmSrc=100; RegWrite=1 with ResultSrc=11 in cycle 3.
- sub (funct7b5=1) -> ALUControl=001 in EXECUTER. addi with instr[30]=1 -> ALUControl=000.
- op=1111111 -> illegal_op pulses in cycle 2, back to FETCH, no writes.
- rst=0 during MEMREAD -> state is FETCH after the next edge and no RegWrite is ever issued for that lw.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control path.
//   Opcode constants, FSM state enum, and the ImmSrc / ALUControl /
//   ResultSrc / ALUSrcA / ALUSrcB select encodings used by the controller,
//   immediate extender and datapath. imm_src() maps an opcode to its
//   immediate format.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_JALR1, S_JALR2,
        S_BRANCH, S_LUI
    } state_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            OP_LUI:    imm_src = IMM_U;
            default:   imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational funct3/funct7 -> ALUControl mapping.
//   i_funct3   : instr[14:12]
//   i_funct7b5 : instr[30], only meaningful for R-type (sub vs add)
//   i_rtype    : 1 for register-register ops; I-type ignores funct7b5
//   o_alu_ctrl : ALUControl encoding
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_rtype,
    output logic [2:0] o_alu_ctrl
);

    always_comb begin
        case (i_funct3)
            3'b000:  o_alu_ctrl = (i_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  o_alu_ctrl = ALU_SLT;
            3'b110:  o_alu_ctrl = ALU_OR;
            3'b111:  o_alu_ctrl = ALU_AND;
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for the multicycle RV32I
// datapath.
//   Inputs : clk, rst (sync, active low), op/funct3/funct7b5 from the IR,
//            zero/neg ALU flags (used only in BRANCH).
//   Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op.
// Outputs decode from the current state so the branch decision can use the
// ALU flags produced in that same cycle.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal_op
);

    state_t     r_state;
    state_t     w_st;
    state_t     w_next;
    logic [2:0] w_alu_dec;
    logic       w_taken;

    alu_decoder u_alu_dec (
        .i_funct3   (funct3),
        .i_funct7b5 (funct7b5),
        .i_rtype    (r_state == S_EXECUTER),
        .o_alu_ctrl (w_alu_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    assign ImmSrc = imm_src(op);

    always_comb begin
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = neg;
            3'b101:  w_taken = !neg;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        // During reset the selects present FETCH so the datapath sees a
        // benign configuration; enables are gated off below.
        w_st       = rst ? r_state : S_FETCH;
        w_next     = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_ADD;
        illegal_op = 1'b0;
        case (w_st)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // Precompute OldPC+imm; branch and jal consume it from ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR1;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_LUI:            w_next = S_LUI;
                    default:           illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = w_alu_dec;
                w_next     = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_alu_dec;
                w_next     = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                // PC <= target from ALUOut while the ALU forms the link value.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_next  = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                w_next  = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = funct3[2] ? ALU_SLT : ALU_SUB;
                PCWrite    = w_taken;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (!rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench. Each instruction pushes its
// expected per-cycle control vector; the bench pops one per cycle and
// compares it with the DUT outputs sampled on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       neg;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int n_chk  = 0;
    int n_fail = 0;
    logic [17:0] q[$];

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4,
                   K_JALR = 5, K_BR = 6, K_LUI = 7, K_ILL = 8;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,
    //  ALUControl,ImmSrc,illegal_op}
    function automatic logic [17:0] mk(input logic pcw, input logic adr,
        input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
        input logic [2:0] imm, input logic ill);
        mk = {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [17:0] obs();
        obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op};
    endfunction

    function automatic logic [2:0] imm_exp(input logic [6:0] o);
        case (o)
            7'b0100011: imm_exp = 3'b001;
            7'b1100011: imm_exp = 3'b010;
            7'b1101111: imm_exp = 3'b011;
            7'b0110111: imm_exp = 3'b100;
            default:    imm_exp = 3'b000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [17:0] got,
                       input logic [17:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic [6:0] o,
                            input logic [2:0] alu, input logic taken);
        logic [2:0] im;
        im = imm_exp(o);
        q.push_back(mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,im,0));
        q.push_back(mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,im,kind == K_ILL));
        case (kind)
            K_LW: begin
                q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,im,0));
                q.push_back(mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,im,0));
                q.push_back(mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,im,0));
            end
            K_SW: begin
                q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,im,0));
                q.push_back(mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,im,0));
            end
            K_R, K_I: begin
                q.push_back(mk(0,0,0,0,0,2'b00,2'b10,
                               (kind == K_R) ? 2'b00 : 2'b01, alu, im, 0));
                q.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,im,0));
            end
            K_JAL: begin
                q.push_back(mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,im,0));
                q.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,im,0));
            end
            K_JALR: begin
                q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,im,0));
                q.push_back(mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,im,0));
                q.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,im,0));
            end
            K_BR:  q.push_back(mk(taken,0,0,0,0,2'b00,2'b10,2'b00,alu,im,0));
            K_LUI: q.push_back(mk(0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,im,0));
            default: ;
        endcase
    endtask

    // Called just after a rising edge; runs ncyc cycles (0 = whole instr).
    task automatic run(input string tag, input int kind, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic n, input logic [2:0] alu,
                       input logic taken, input int ncyc);
        int len;
        op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
        push_exp(kind, o, alu, taken);
        len = (ncyc == 0) ? q.size() : ncyc;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, c), obs(), q.pop_front());
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    initial begin
        rst = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        zero = 1'b0; neg = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset", obs(), mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        end
        @(posedge clk); #1; rst = 1'b1;

        run("lw",    K_LW,   7'b0000011, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        run("sw",    K_SW,   7'b0100011, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        run("beq_t", K_BR,   7'b1100011, 3'b000, 0, 1, 0, 3'b001, 1, 0);
        run("beq_n", K_BR,   7'b1100011, 3'b000, 0, 0, 0, 3'b001, 0, 0);
        run("bne_t", K_BR,   7'b1100011, 3'b001, 0, 0, 1, 3'b001, 1, 0);
        run("blt_t", K_BR,   7'b1100011, 3'b100, 0, 0, 1, 3'b101, 1, 0);
        run("bge_n", K_BR,   7'b1100011, 3'b101, 0, 1, 1, 3'b101, 0, 0);
        run("bge_t", K_BR,   7'b1100011, 3'b101, 0, 0, 0, 3'b101, 1, 0);
        run("jal",   K_JAL,  7'b1101111, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        run("jalr",  K_JALR, 7'b1100111, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        run("lui",   K_LUI,  7'b0110111, 3'b010, 0, 0, 0, 3'b000, 0, 0);
        run("add",   K_R,    7'b0110011, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        run("sub",   K_R,    7'b0110011, 3'b000, 1, 0, 0, 3'b001, 0, 0);
        run("and",   K_R,    7'b0110011, 3'b111, 0, 0, 0, 3'b010, 0, 0);
        run("or",    K_R,    7'b0110011, 3'b110, 0, 0, 0, 3'b011, 0, 0);
        run("slt",   K_R,    7'b0110011, 3'b010, 0, 0, 0, 3'b101, 0, 0);
        run("addi7", K_I,    7'b0010011, 3'b000, 1, 0, 0, 3'b000, 0, 0);
        run("andi",  K_I,    7'b0010011, 3'b111, 0, 0, 0, 3'b010, 0, 0);
        run("ori",   K_I,    7'b0010011, 3'b110, 0, 0, 0, 3'b011, 0, 0);
        run("slti",  K_I,    7'b0010011, 3'b010, 0, 0, 0, 3'b101, 0, 0);
        run("ill",   K_ILL,  7'b1111111, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        run("postill", K_LUI, 7'b0110111, 3'b000, 0, 0, 0, 3'b000, 0, 0);

        // Abort an lw in MEMREAD: reset for one edge, then FETCH with no
        // write-back ever issued for the discarded load.
        run("lwabort", K_LW, 7'b0000011, 3'b010, 0, 0, 0, 3'b000, 0, 3);
        @(negedge clk);
        chk("lwabort_memread", obs(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        #1 rst = 1'b0;
        #1 chk("midrst", obs(), mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        @(posedge clk); #1; rst = 1'b1;
        run("afterrst", K_LW, 7'b0000011, 3'b010, 0, 0, 0, 3'b000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
